// File: rtl/axi4_lite_read_slave_if.sv
// AXI4-Lite read channel (AR/R) plus the single-beat backing-memory read port.
// The slave modport is the responder's view; master is the view of whatever drives requests and models memory.
interface axi4_lite_read_slave_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic [ADDR_W-1:0] AR_ADDR;
    logic              AR_VALID;
    logic              AR_READY;
    logic [DATA_W-1:0] R_DATA;
    logic [1:0]        R_RESP;
    logic              R_VALID;
    logic              R_READY;
    logic              MEM_REQ;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_RDATA;
    logic              MEM_ACK;

    modport slave (
        input  AR_ADDR, AR_VALID, R_READY, MEM_RDATA, MEM_ACK,
        output AR_READY, R_DATA, R_RESP, R_VALID, MEM_REQ, MEM_ADDR
    );

    modport master (
        output AR_ADDR, AR_VALID, R_READY, MEM_RDATA, MEM_ACK,
        input  AR_READY, R_DATA, R_RESP, R_VALID, MEM_REQ, MEM_ADDR
    );
endinterface

// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite read responder: one transaction in flight, address window/alignment decode,
// a single read to the backing store and a bounded wait for its acknowledge.
module axi4_lite_read_slave #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       DATA_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
    parameter logic [ADDR_W-1:0] SIZE      = ADDR_W'(64'h0800_0000),
    parameter int unsigned       TIMEOUT   = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    axi4_lite_read_slave_if.slave bus,
    output logic [15:0]          ERR_CNT
);

    localparam int unsigned OFF_W       = $clog2(DATA_W / 8);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [15:0] TMO_LAST    = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        RESP     = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t            state_q, state_d;
    logic              ar_ready_q, ar_ready_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic [1:0]        r_resp_q, r_resp_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [15:0]       tcnt_q, tcnt_d;

    logic              misaligned;
    logic              out_of_range;
    logic [ADDR_W:0]   addr_ext;
    logic [ADDR_W:0]   base_ext;
    logic [ADDR_W:0]   limit_ext;
    logic [ADDR_W-1:0] offset;

    generate
        if (OFF_W == 0) begin : g_no_align
            assign misaligned = 1'b0;
        end else begin : g_align
            assign misaligned = |bus.AR_ADDR[OFF_W-1:0];
        end
    endgenerate

    // One extra bit so BASE_ADDR+SIZE cannot wrap past the top of the address space.
    assign addr_ext     = {1'b0, bus.AR_ADDR};
    assign base_ext     = {1'b0, BASE_ADDR};
    assign limit_ext    = base_ext + {1'b0, SIZE};
    assign out_of_range = (addr_ext < base_ext) || (addr_ext >= limit_ext);
    assign offset       = bus.AR_ADDR - BASE_ADDR;

    always_comb begin
        state_d    = state_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        err_cnt_d  = err_cnt_q;
        tcnt_d     = tcnt_q;

        case (state_q)
            IDLE: begin
                if (bus.AR_VALID && ar_ready_q) begin
                    if (misaligned) begin
                        state_d  = RESP;
                        r_resp_d = RESP_SLVERR;
                        r_data_d = '0;
                    end else if (out_of_range) begin
                        state_d  = RESP;
                        r_resp_d = RESP_DECERR;
                        r_data_d = '0;
                    end else begin
                        state_d    = MEM_WAIT;
                        mem_req_d  = 1'b1;
                        mem_addr_d = offset;
                        tcnt_d     = 16'd0;
                    end
                end
            end
            MEM_WAIT: begin
                // An acknowledge on the last allowed cycle still beats the timeout.
                if (bus.MEM_ACK) begin
                    state_d  = RESP;
                    r_data_d = bus.MEM_RDATA;
                    r_resp_d = RESP_OKAY;
                end else if ((TIMEOUT != 0) && (tcnt_q == TMO_LAST)) begin
                    state_d  = RESP;
                    r_data_d = '0;
                    r_resp_d = RESP_SLVERR;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            RESP: begin
                if (bus.R_READY) begin
                    state_d = IDLE;
                    if (r_resp_q != RESP_OKAY) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ar_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            ar_ready_q <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            err_cnt_q  <= 16'd0;
            tcnt_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            ar_ready_q <= ar_ready_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            err_cnt_q  <= err_cnt_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign bus.AR_READY = ar_ready_q;
    assign bus.R_VALID  = (state_q == RESP);
    assign bus.R_DATA   = r_data_q;
    assign bus.R_RESP   = r_resp_q;
    assign bus.MEM_REQ  = mem_req_q;
    assign bus.MEM_ADDR = mem_addr_q;
    assign ERR_CNT      = err_cnt_q;

endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// Directed bench for axi4_lite_read_slave: decode, memory handshake, timeout, back-pressure and mid-flight reset.
module tb_axi4_lite_read_slave;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam logic [63:0] BASE   = 64'h8000_0000;
    localparam logic [63:0] SIZE   = 64'h0800_0000;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] ERR_CNT;

    int n_chk   = 0;
    int n_pass  = 0;
    int exp_err = 0;

    always #5 CLK = ~CLK;

    axi4_lite_read_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi4_lite_read_slave #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BASE_ADDR(BASE),
        .SIZE     (SIZE),
        .TIMEOUT  (16)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .bus    (bus),
        .ERR_CNT(ERR_CNT)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench in cycle T+1 of the handshake.
    task automatic issue(input logic [63:0] addr);
        chk("ar_ready_before_issue", bus.AR_READY, 1);
        bus.AR_ADDR  = addr;
        bus.AR_VALID = 1'b1;
        step();
        bus.AR_VALID = 1'b0;
        bus.AR_ADDR  = 64'hFFFF_FFFF_FFFF_FFF4;
        chk("ar_ready_after_issue", bus.AR_READY, 0);
    endtask

    task automatic accept();
        bus.R_READY = 1'b1;
        step();
        bus.R_READY = 1'b0;
        chk("r_valid_after_accept", bus.R_VALID, 0);
        chk("ar_ready_after_accept", bus.AR_READY, 1);
        chk("err_cnt_after_accept", ERR_CNT, exp_err);
    endtask

    // Ends in the first RESP cycle without accepting.
    task automatic do_ok(input logic [63:0] addr, input logic [63:0] data, input int delay);
        issue(addr);
        chk("mem_req_t1", bus.MEM_REQ, 1);
        chk("mem_addr_t1", bus.MEM_ADDR, addr - BASE);
        chk("r_valid_t1", bus.R_VALID, 0);
        for (int i = 0; i < delay; i++) begin
            step();
            chk("r_valid_wait", bus.R_VALID, 0);
            chk("mem_req_once", bus.MEM_REQ, 0);
        end
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = data;
        step();
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = 64'h0;
        chk("ok_r_valid", bus.R_VALID, 1);
        chk("ok_r_resp", bus.R_RESP, 2'b00);
        chk("ok_r_data", bus.R_DATA, data);
        chk("ok_mem_req_low", bus.MEM_REQ, 0);
    endtask

    task automatic do_err(input logic [63:0] addr, input logic [1:0] resp);
        issue(addr);
        chk("err_mem_req", bus.MEM_REQ, 0);
        chk("err_r_valid", bus.R_VALID, 1);
        chk("err_r_resp", bus.R_RESP, resp);
        chk("err_r_data", bus.R_DATA, 0);
        chk("err_cnt_before_hs", ERR_CNT, exp_err);
        exp_err++;
        accept();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ar_ready", bus.AR_READY, 0);
        chk("rst_r_valid", bus.R_VALID, 0);
        chk("rst_r_data", bus.R_DATA, 0);
        chk("rst_r_resp", bus.R_RESP, 0);
        chk("rst_mem_req", bus.MEM_REQ, 0);
        chk("rst_mem_addr", bus.MEM_ADDR, 0);
        chk("rst_err_cnt", ERR_CNT, 0);
    endtask

    task automatic release_reset();
        step();
        RST_N = 1'b1;
        chk("ar_ready_before_edge", bus.AR_READY, 0);
        step();
        chk("ar_ready_after_release", bus.AR_READY, 1);
        chk("r_valid_after_release", bus.R_VALID, 0);
    endtask

    initial begin
        int n;
        bus.AR_ADDR   = 64'h0;
        bus.AR_VALID  = 1'b0;
        bus.R_READY   = 1'b0;
        bus.MEM_RDATA = 64'h0;
        bus.MEM_ACK   = 1'b0;

        // Power-on reset
        repeat (3) step();
        chk_reset_outputs();
        release_reset();

        // Aligned in-window read, ACK in the same cycle as MEM_REQ
        do_ok(BASE + 64'd8, 64'hDEAD_BEEF_0123_4567, 0);
        accept();

        // Decode errors; misalignment takes priority over window check
        do_err(BASE + 64'd4, 2'b10);
        do_err(BASE + SIZE, 2'b11);
        do_err(BASE - 64'd8, 2'b11);
        do_err(BASE - 64'd4, 2'b10);

        // Last beat of the window
        do_ok(BASE + SIZE - 64'd8, 64'h0123_4567_89AB_CDEF, 1);
        accept();

        // Timeout, then a late ACK while holding the response
        issue(BASE + 64'h40);
        n = 0;
        while (!bus.R_VALID && n < 40) begin
            step();
            n++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_r_resp", bus.R_RESP, 2'b10);
        chk("timeout_r_data", bus.R_DATA, 0);
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 64'h5555_AAAA_5555_AAAA;
        step();
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = 64'h0;
        chk("late_ack_r_data", bus.R_DATA, 0);
        chk("late_ack_r_resp", bus.R_RESP, 2'b10);
        chk("late_ack_r_valid", bus.R_VALID, 1);
        exp_err++;
        accept();

        // ACK while idle has no effect
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 64'h1111_2222_3333_4444;
        step();
        bus.MEM_ACK   = 1'b0;
        chk("idle_ack_r_valid", bus.R_VALID, 0);
        chk("idle_ack_ar_ready", bus.AR_READY, 1);

        // ACK on the 16th MEM_WAIT cycle wins
        do_ok(BASE + 64'h80, 64'hCAFE_F00D_0000_0016, 15);
        accept();

        // Back-pressure: five cycles of R_READY low, AR_VALID asserted meanwhile
        do_ok(BASE + 64'h100, 64'hA5A5_5A5A_0F0F_F0F0, 0);
        bus.AR_ADDR  = BASE + 64'd4;
        bus.AR_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_r_valid", bus.R_VALID, 1);
            chk("hold_r_data", bus.R_DATA, 64'hA5A5_5A5A_0F0F_F0F0);
            chk("hold_r_resp", bus.R_RESP, 2'b00);
            chk("hold_ar_ready", bus.AR_READY, 0);
            step();
        end
        bus.AR_VALID = 1'b0;
        accept();
        step();
        chk("no_stray_txn", bus.R_VALID, 0);

        // R_READY high before R_VALID
        bus.R_READY = 1'b1;
        issue(BASE + 64'd2);
        chk("early_rdy_r_valid", bus.R_VALID, 1);
        chk("early_rdy_r_resp", bus.R_RESP, 2'b10);
        step();
        bus.R_READY = 1'b0;
        exp_err++;
        chk("early_rdy_done", bus.R_VALID, 0);
        chk("early_rdy_err_cnt", ERR_CNT, exp_err);

        // Reset during MEM_WAIT
        issue(BASE + 64'h10);
        chk("mw_mem_req", bus.MEM_REQ, 1);
        RST_N = 1'b0;
        #1;
        chk_reset_outputs();
        exp_err = 0;
        release_reset();
        do_ok(BASE + 64'h18, 64'h0BAD_C0DE_0000_0001, 2);
        accept();

        // Reset during RESP
        issue(BASE + SIZE + 64'd8);
        chk("resp_before_rst", bus.R_VALID, 1);
        RST_N = 1'b0;
        #1;
        chk_reset_outputs();
        release_reset();
        do_ok(BASE, 64'h7777_8888_9999_0000, 0);
        accept();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
